// File: rtl/dmem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares the data-memory port between the EX stage and a debug
//            master, with a watchdog that aborts unacknowledged accesses.
// Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 15,
  parameter int EX_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_done,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              ex_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] c_wdog_last = 8'(TIMEOUT - 1);

  state_t            r_state, w_state;
  logic              r_id, w_id;            // 1 = debug owns the access
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_mem_a, w_mem_a;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic              r_mem_rd, w_mem_rd;
  logic              r_mem_wr, w_mem_wr;
  logic [DATA_W-1:0] r_rdata_hold, w_rdata_hold;
  logic              r_timeout, w_timeout;
  logic [7:0]        r_wdog, w_wdog;
  logic              r_last, w_last;        // requester served last, 1 = debug
  logic              r_ex_done, w_ex_done;
  logic              r_dbg_done, w_dbg_done;
  logic              r_err, w_err;
  logic [DATA_W-1:0] r_ex_rdata, w_ex_rdata;
  logic [DATA_W-1:0] r_dbg_rdata, w_dbg_rdata;
  logic              w_pick_dbg;
  logic              w_done_pulse;

  // Debug wins only when EX is idle, or on a round-robin tie after EX was served.
  assign w_pick_dbg   = dbg_req & (~ex_req | ((EX_PRIORITY == 0) && !r_last));
  // A requester still sees its own req high during its done cycle; no grant then.
  assign w_done_pulse = r_ex_done | r_dbg_done;

  always_comb begin
    w_state      = r_state;
    w_id         = r_id;
    w_we         = r_we;
    w_mem_a      = r_mem_a;
    w_mem_wdata  = r_mem_wdata;
    w_mem_rd     = r_mem_rd;
    w_mem_wr     = r_mem_wr;
    w_rdata_hold = r_rdata_hold;
    w_timeout    = r_timeout;
    w_wdog       = r_wdog;
    w_last       = r_last;
    w_ex_done    = 1'b0;
    w_dbg_done   = 1'b0;
    w_err        = 1'b0;
    w_ex_rdata   = r_ex_rdata;
    w_dbg_rdata  = r_dbg_rdata;

    case (r_state)
      ST_IDLE: begin
        if ((ex_req | dbg_req) & ~w_done_pulse) begin
          w_id        = w_pick_dbg;
          w_we        = w_pick_dbg ? dbg_we    : ex_we;
          w_mem_a     = w_pick_dbg ? dbg_addr  : ex_addr;
          w_mem_wdata = w_pick_dbg ? dbg_wdata : ex_wdata;
          w_mem_rd    = ~w_we;
          w_mem_wr    = w_we;
          w_wdog      = 8'd0;
          w_timeout   = 1'b0;
          w_state     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          w_rdata_hold = mem_rdata;
          w_mem_rd     = 1'b0;
          w_mem_wr     = 1'b0;
          w_state      = ST_RESP;
        end else if (r_wdog == c_wdog_last) begin
          w_rdata_hold = '0;
          w_timeout    = 1'b1;
          w_mem_rd     = 1'b0;
          w_mem_wr     = 1'b0;
          w_state      = ST_RESP;
        end else begin
          w_wdog = r_wdog + 8'd1;
        end
      end
      ST_RESP: begin
        w_err  = r_timeout;
        w_last = r_id;
        if (r_id) begin
          w_dbg_done = 1'b1;
          if (!r_we) w_dbg_rdata = r_rdata_hold;
        end else begin
          w_ex_done = 1'b1;
          if (!r_we) w_ex_rdata = r_rdata_hold;
        end
        w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_mem_a      <= '0;
      r_mem_wdata  <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_rdata_hold <= '0;
      r_timeout    <= 1'b0;
      r_wdog       <= 8'd0;
      r_last       <= 1'b0;
      r_ex_done    <= 1'b0;
      r_dbg_done   <= 1'b0;
      r_err        <= 1'b0;
      r_ex_rdata   <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state      <= w_state;
      r_id         <= w_id;
      r_we         <= w_we;
      r_mem_a      <= w_mem_a;
      r_mem_wdata  <= w_mem_wdata;
      r_mem_rd     <= w_mem_rd;
      r_mem_wr     <= w_mem_wr;
      r_rdata_hold <= w_rdata_hold;
      r_timeout    <= w_timeout;
      r_wdog       <= w_wdog;
      r_last       <= w_last;
      r_ex_done    <= w_ex_done;
      r_dbg_done   <= w_dbg_done;
      r_err        <= w_err;
      r_ex_rdata   <= w_ex_rdata;
      r_dbg_rdata  <= w_dbg_rdata;
    end
  end

  assign ex_done   = r_ex_done;
  assign ex_rdata  = r_ex_rdata;
  assign ex_stall  = ex_req & ~r_ex_done;
  assign dbg_done  = r_dbg_done;
  assign dbg_rdata = r_dbg_rdata;
  assign err       = r_err;
  assign mem_a     = r_mem_a;
  assign mem_wdata = r_mem_wdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Two arbiters (index 0 round-robin, index 1 EX priority) checked
//            with directed steps and a transaction-level random model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int c_aw  = 32;
  localparam int c_dw  = 32;
  localparam int c_tmo = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            ex_req[2], ex_we[2], dbg_req[2], dbg_we[2];
  logic [c_aw-1:0] ex_addr[2], dbg_addr[2], mem_a[2];
  logic [c_dw-1:0] ex_wdata[2], dbg_wdata[2], mem_wdata[2];
  logic            ex_done[2], ex_stall[2], dbg_done[2], err[2], mem_rd[2], mem_wr[2];
  logic [c_dw-1:0] ex_rdata[2], dbg_rdata[2], mem_rdata[2];
  logic            mem_ready[2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dmem_port_arbiter #(
      .ADDR_W(c_aw), .DATA_W(c_dw), .TIMEOUT(c_tmo), .EX_PRIORITY(k)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ex_req(ex_req[k]), .ex_we(ex_we[k]), .ex_addr(ex_addr[k]), .ex_wdata(ex_wdata[k]),
      .ex_done(ex_done[k]), .ex_rdata(ex_rdata[k]), .ex_stall(ex_stall[k]),
      .dbg_req(dbg_req[k]), .dbg_we(dbg_we[k]), .dbg_addr(dbg_addr[k]), .dbg_wdata(dbg_wdata[k]),
      .dbg_done(dbg_done[k]), .dbg_rdata(dbg_rdata[k]), .err(err[k]),
      .mem_a(mem_a[k]), .mem_wdata(mem_wdata[k]), .mem_rd(mem_rd[k]), .mem_wr(mem_wr[k]),
      .mem_rdata(mem_rdata[k]), .mem_ready(mem_ready[k])
    );
  end

  // Memory device: acks after lat wait cycles (lat<0: random 0..3), random or fixed data.
  int              lat[2] = '{0, 0};
  logic            use_fix[2] = '{1'b0, 1'b0};
  logic [c_dw-1:0] fix_data[2];
  logic [c_dw-1:0] resp_data[2];
  int              wcnt[2] = '{0, 0};
  int              cur_lat[2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_rd[k] || mem_wr[k]) begin
        if (wcnt[k] == 0) cur_lat[k] = (lat[k] < 0) ? int'($urandom_range(0, 3)) : lat[k];
        mem_rdata[k] = use_fix[k] ? fix_data[k] : $urandom;
        mem_ready[k] = (wcnt[k] == cur_lat[k]);
        if (mem_ready[k]) resp_data[k] = mem_rdata[k];
        wcnt[k]++;
      end else begin
        mem_ready[k] = 1'($urandom_range(0, 1));
        mem_rdata[k] = $urandom;
        wcnt[k]      = 0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    for (int k = 0; k < 2; k++) begin
      ex_req[k] = 1'b0; ex_we[k] = 1'b0; ex_addr[k] = '0; ex_wdata[k] = '0;
      dbg_req[k] = 1'b0; dbg_we[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
    end
  endtask

  // Random-phase model state
  bit              pend_ex[2], pend_dbg[2], snap_ex[2], snap_dbg[2];
  bit              active[2], act_dbg[2], last_dbg[2], prev_strobe[2];
  bit              seen[2], got_ex[2], got_dbg[2];
  logic [c_aw-1:0] seen_a[2];
  logic [c_dw-1:0] exp_ex_rd[2], exp_dbg_rd[2];
  bit              strobe, win_dbg, w_we;

  initial begin
    rst_n = 1'b0;
    clr_req();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_strobes", {mem_rd[k], mem_wr[k]}, 0);
      chk("rst_pulses", {ex_done[k], dbg_done[k], err[k]}, 0);
      chk("rst_ex_rdata", ex_rdata[k], 0);
      chk("rst_dbg_rdata", dbg_rdata[k], 0);
      chk("rst_mem_a", mem_a[k], 0);
      chk("rst_stall", ex_stall[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // EX load, immediate ack
    use_fix[1] = 1'b1; fix_data[1] = 32'hDEADBEEF; lat[1] = 0;
    ex_addr[1] = 32'h10; ex_we[1] = 1'b0; ex_req[1] = 1'b1;
    #1;
    chk("ld_c0_stall", ex_stall[1], 1);
    chk("ld_c0_rd", mem_rd[1], 0);
    @(negedge clk);
    chk("ld_c1_rd", mem_rd[1], 1);
    chk("ld_c1_a", mem_a[1], 32'h10);
    chk("ld_c1_stall", ex_stall[1], 1);
    @(negedge clk);
    chk("ld_c2_rd", mem_rd[1], 0);
    chk("ld_c2_stall", ex_stall[1], 1);
    chk("ld_c2_done", ex_done[1], 0);
    @(negedge clk);
    chk("ld_c3_done", ex_done[1], 1);
    chk("ld_c3_rdata", ex_rdata[1], 32'hDEADBEEF);
    chk("ld_c3_stall", ex_stall[1], 0);
    chk("ld_c3_err", err[1], 0);
    ex_req[1] = 1'b0;
    @(negedge clk);
    chk("ld_c4_done", ex_done[1], 0);
    chk("ld_c4_rdata_hold", ex_rdata[1], 32'hDEADBEEF);

    // EX store, ack after four strobe cycles
    lat[1] = 3;
    ex_addr[1] = 32'h20; ex_wdata[1] = 32'h1234; ex_we[1] = 1'b1; ex_req[1] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("st_wr", mem_wr[1], 1);
      chk("st_rd", mem_rd[1], 0);
      chk("st_a", mem_a[1], 32'h20);
      chk("st_wdata", mem_wdata[1], 32'h1234);
      chk("st_early_done", ex_done[1], 0);
    end
    @(negedge clk);
    chk("st_wr_drop", mem_wr[1], 0);
    chk("st_c5_done", ex_done[1], 0);
    @(negedge clk);
    chk("st_done", ex_done[1], 1);
    chk("st_rdata_unchanged", ex_rdata[1], 32'hDEADBEEF);
    ex_req[1] = 1'b0;
    @(negedge clk);
    chk("st_single_done", ex_done[1], 0);
    use_fix[1] = 1'b0;

    // Simultaneous requests on both arbiters
    lat = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      ex_req[k] = 1'b1;  ex_we[k] = 1'b0;  ex_addr[k] = 32'h100;
      dbg_req[k] = 1'b1; dbg_we[k] = 1'b0; dbg_addr[k] = 32'h200;
    end
    @(negedge clk);
    chk("tie_rr_first_a", mem_a[0], 32'h200);
    chk("tie_pri_first_a", mem_a[1], 32'h100);
    @(negedge clk);
    @(negedge clk);
    chk("tie_rr_dbg_done", dbg_done[0], 1);
    chk("tie_rr_ex_wait", ex_done[0], 0);
    chk("tie_pri_ex_done", ex_done[1], 1);
    chk("tie_pri_dbg_wait", dbg_done[1], 0);
    chk("tie_rr_rdata", dbg_rdata[0], resp_data[0]);
    chk("tie_pri_rdata", ex_rdata[1], resp_data[1]);
    dbg_req[0] = 1'b0; ex_req[1] = 1'b0;
    seen = '{0, 0}; got_ex = '{0, 0}; got_dbg = '{0, 0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!seen[k] && mem_rd[k]) begin seen[k] = 1'b1; seen_a[k] = mem_a[k]; end
        if (ex_done[k])  begin got_ex[k] = 1'b1;  ex_req[k] = 1'b0;  end
        if (dbg_done[k]) begin got_dbg[k] = 1'b1; dbg_req[k] = 1'b0; end
      end
    end
    chk("tie_rr_second_seen", seen[0], 1);
    chk("tie_pri_second_seen", seen[1], 1);
    chk("tie_rr_second_a", seen_a[0], 32'h100);
    chk("tie_pri_second_a", seen_a[1], 32'h200);
    chk("tie_rr_second_done", {got_ex[0], got_dbg[0]}, 2'b10);
    chk("tie_pri_second_done", {got_ex[1], got_dbg[1]}, 2'b01);
    clr_req();

    // Watchdog abort on a debug read
    lat[1] = 255;
    dbg_addr[1] = 32'h300; dbg_we[1] = 1'b0; dbg_req[1] = 1'b1;
    for (int i = 1; i <= c_tmo; i++) begin
      @(negedge clk);
      chk("tmo_rd_held", mem_rd[1], 1);
      chk("tmo_no_done", dbg_done[1], 0);
    end
    @(negedge clk);
    chk("tmo_rd_drop", mem_rd[1], 0);
    chk("tmo_err_early", err[1], 0);
    @(negedge clk);
    chk("tmo_done", dbg_done[1], 1);
    chk("tmo_err", err[1], 1);
    chk("tmo_rdata_zero", dbg_rdata[1], 0);
    chk("tmo_no_ex_done", ex_done[1], 0);
    dbg_req[1] = 1'b0;
    @(negedge clk);
    chk("tmo_err_pulse", {err[1], dbg_done[1]}, 0);

    // Reset during an access
    lat = '{255, 255};
    for (int k = 0; k < 2; k++) begin
      ex_addr[k] = 32'h44; ex_we[k] = 1'b0; ex_req[k] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_rd_before", {mem_rd[0], mem_rd[1]}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_async_drop", {mem_rd[0], mem_rd[1]}, 0);
    clr_req();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        chk("rstmid_quiet", {ex_done[k], dbg_done[k], err[k], mem_rd[k]}, 0);
    end

    // Requester inputs change mid-access; req dropped before done
    use_fix[1] = 1'b1; fix_data[1] = 32'hCAFEF00D; lat[1] = 3;
    ex_addr[1] = 32'h10; ex_we[1] = 1'b0; ex_req[1] = 1'b1;
    @(negedge clk);
    chk("mid_a_c1", mem_a[1], 32'h10);
    ex_addr[1] = 32'h40; ex_we[1] = 1'b1; ex_wdata[1] = 32'h5555;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("mid_a_stable", mem_a[1], 32'h10);
      chk("mid_rd_stable", {mem_rd[1], mem_wr[1]}, 2'b10);
      ex_req[1] = 1'b0;
    end
    @(negedge clk);
    chk("mid_rd_drop", mem_rd[1], 0);
    @(negedge clk);
    chk("mid_done_after_drop", ex_done[1], 1);
    chk("mid_rdata", ex_rdata[1], 32'hCAFEF00D);
    @(negedge clk);
    chk("mid_done_once", ex_done[1], 0);
    use_fix[1] = 1'b0;
    clr_req();

    // Random traffic against a transaction-level model
    lat = '{-1, -1};
    exp_ex_rd  = '{32'h0, 32'hCAFEF00D};
    exp_dbg_rd = '{32'h0, 32'h0};
    for (int k = 0; k < 2; k++) begin
      pend_ex[k] = 0; pend_dbg[k] = 0; snap_ex[k] = 0; snap_dbg[k] = 0;
      active[k] = 0; act_dbg[k] = 0; last_dbg[k] = 0; prev_strobe[k] = 0;
    end
    for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        strobe = mem_rd[k] | mem_wr[k];
        chk("rnd_stall", ex_stall[k], ex_req[k] & ~ex_done[k]);
        if (strobe && !prev_strobe[k]) begin
          chk("rnd_grant_busy", active[k], 0);
          chk("rnd_grant_no_req", snap_ex[k] | snap_dbg[k], 1);
          // Tie: EX-priority unit always takes EX; round-robin takes the one not served last.
          if (snap_ex[k] && snap_dbg[k]) win_dbg = (k == 0) ? !last_dbg[k] : 1'b0;
          else                           win_dbg = snap_dbg[k];
          active[k] = 1'b1; act_dbg[k] = win_dbg;
        end
        if (strobe) begin
          w_we = act_dbg[k] ? dbg_we[k] : ex_we[k];
          chk("rnd_mem_a", mem_a[k], act_dbg[k] ? dbg_addr[k] : ex_addr[k]);
          chk("rnd_strobe_dir", {mem_rd[k], mem_wr[k]}, {~w_we, w_we});
          if (w_we) chk("rnd_wdata", mem_wdata[k], act_dbg[k] ? dbg_wdata[k] : ex_wdata[k]);
        end
        if (ex_done[k] | dbg_done[k]) begin
          chk("rnd_done_idle", active[k], 1);
          chk("rnd_done_who", {ex_done[k], dbg_done[k]}, {~act_dbg[k], act_dbg[k]});
          chk("rnd_err", err[k], 0);
          if (act_dbg[k]) begin
            if (!dbg_we[k]) exp_dbg_rd[k] = resp_data[k];
            pend_dbg[k] = 0; dbg_req[k] = 1'b0;
          end else begin
            if (!ex_we[k]) exp_ex_rd[k] = resp_data[k];
            pend_ex[k] = 0; ex_req[k] = 1'b0;
          end
          last_dbg[k] = act_dbg[k];
          active[k]   = 1'b0;
        end
        chk("rnd_ex_rdata", ex_rdata[k], exp_ex_rd[k]);
        chk("rnd_dbg_rdata", dbg_rdata[k], exp_dbg_rd[k]);
        prev_strobe[k] = strobe;
        if (!pend_ex[k] && cyc_i < 2900 && $urandom_range(0, 3) == 0) begin
          pend_ex[k] = 1; ex_req[k] = 1'b1; ex_we[k] = 1'($urandom_range(0, 1));
          ex_addr[k] = $urandom & 32'h0000_0FFC; ex_wdata[k] = $urandom;
        end
        if (!pend_dbg[k] && cyc_i < 2900 && $urandom_range(0, 3) == 0) begin
          pend_dbg[k] = 1; dbg_req[k] = 1'b1; dbg_we[k] = 1'($urandom_range(0, 1));
          dbg_addr[k] = $urandom & 32'h0000_0FFC; dbg_wdata[k] = $urandom;
        end
        snap_ex[k]  = pend_ex[k];
        snap_dbg[k] = pend_dbg[k];
      end
    end
    for (int k = 0; k < 2; k++)
      chk("rnd_drain", {pend_ex[k], pend_dbg[k], active[k]}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
